// File: rtl/shift_operand_stage_pkg.sv
// Shared definitions for the ID->EX shift operand stage: shift encodings,
// default widths and the forwarding hit test.
package shift_operand_stage_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned SHAMT_W_DEF = 5;
    localparam int unsigned REG_IDX_W   = 5;

    // Shifter operation encodings; SH_RSVD is never issued by the decoder.
    typedef enum logic [1:0] {
        SH_LSL  = 2'b00,
        SH_LSR  = 2'b01,
        SH_ASR  = 2'b10,
        SH_RSVD = 2'b11
    } sh_op_e;

    // A producer forwards to a source only if it writes, targets that source,
    // and the source is not x0.
    function automatic logic fwd_hit(input logic                 reg_write,
                                     input logic [REG_IDX_W-1:0] rd,
                                     input logic [REG_IDX_W-1:0] rs);
        return reg_write && (rs != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/shift_operand_stage_fwd_mux.sv
// Forwarding select for one EX-stage source register: MEM result, WB result,
// or the value captured from the register file.
module shift_operand_stage_fwd_mux
    import shift_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [REG_IDX_W-1:0] i_rs,
    input  logic [XLEN-1:0]      i_stored,
    input  logic                 i_reg_write_m,
    input  logic [REG_IDX_W-1:0] i_rd_m,
    input  logic [XLEN-1:0]      i_alu_result_m,
    input  logic                 i_reg_write_w,
    input  logic [REG_IDX_W-1:0] i_rd_w,
    input  logic [XLEN-1:0]      i_result_w,
    output logic [XLEN-1:0]      o_data
);

    // MEM is the younger producer, so it wins over WB when both match.
    always_comb begin
        o_data = i_stored;
        if (fwd_hit(i_reg_write_m, i_rd_m, i_rs)) begin
            o_data = i_alu_result_m;
        end else if (fwd_hit(i_reg_write_w, i_rd_w, i_rs)) begin
            o_data = i_result_w;
        end
    end

endmodule

// File: rtl/shift_operand_stage.sv
// ID->EX pipeline register for shift instructions. Captures the decoded op,
// forwards MEM/WB results onto the stored operands and drives the shifter.
module shift_operand_stage
    import shift_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 ValidD,
    input  logic [1:0]           ShD,
    input  logic                 ShamtSrcD,
    input  logic [SHAMT_W-1:0]   ShamtImmD,
    input  logic [REG_IDX_W-1:0] Rs1D,
    input  logic [REG_IDX_W-1:0] Rs2D,
    input  logic [REG_IDX_W-1:0] RdD,
    input  logic [XLEN-1:0]      RD1D,
    input  logic [XLEN-1:0]      RD2D,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 RegWriteM,
    input  logic [REG_IDX_W-1:0] RdM,
    input  logic [XLEN-1:0]      ALUResultM,
    input  logic                 RegWriteW,
    input  logic [REG_IDX_W-1:0] RdW,
    input  logic [XLEN-1:0]      ResultW,
    output logic                 ValidE,
    output logic [1:0]           ShE,
    output logic [SHAMT_W-1:0]   ShamtE,
    output logic [XLEN-1:0]      ShInE,
    output logic [REG_IDX_W-1:0] RdE
);

    logic                 r_valid;
    logic [1:0]           r_sh;
    logic                 r_shamt_src;
    logic [SHAMT_W-1:0]   r_shamt_imm;
    logic [REG_IDX_W-1:0] r_rs1;
    logic [REG_IDX_W-1:0] r_rs2;
    logic [REG_IDX_W-1:0] r_rd;
    logic [XLEN-1:0]      r_rd1;
    logic [XLEN-1:0]      r_rd2;

    logic [XLEN-1:0]      w_fwd1;
    logic [XLEN-1:0]      w_fwd2;
    logic [SHAMT_W-1:0]   w_shamt;

    shift_operand_stage_fwd_mux #(
        .XLEN (XLEN)
    ) u_fwd_rs1 (
        .i_rs           (r_rs1),
        .i_stored       (r_rd1),
        .i_reg_write_m  (RegWriteM),
        .i_rd_m         (RdM),
        .i_alu_result_m (ALUResultM),
        .i_reg_write_w  (RegWriteW),
        .i_rd_w         (RdW),
        .i_result_w     (ResultW),
        .o_data         (w_fwd1)
    );

    shift_operand_stage_fwd_mux #(
        .XLEN (XLEN)
    ) u_fwd_rs2 (
        .i_rs           (r_rs2),
        .i_stored       (r_rd2),
        .i_reg_write_m  (RegWriteM),
        .i_rd_m         (RdM),
        .i_alu_result_m (ALUResultM),
        .i_reg_write_w  (RegWriteW),
        .i_rd_w         (RdW),
        .i_result_w     (ResultW),
        .o_data         (w_fwd2)
    );

    // EX register bank: reset > flush > stall (refresh operands) > load.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_valid     <= 1'b0;
            r_sh        <= '0;
            r_shamt_src <= 1'b0;
            r_shamt_imm <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rd1       <= '0;
            r_rd2       <= '0;
        end else if (FlushE) begin
            r_valid     <= 1'b0;
            r_sh        <= '0;
            r_shamt_src <= 1'b0;
            r_shamt_imm <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rd1       <= '0;
            r_rd2       <= '0;
        end else if (StallE) begin
            // Latch forwarded values so a producer retiring from WB mid-stall
            // is not lost; re-latching the same value is harmless.
            r_rd1 <= w_fwd1;
            r_rd2 <= w_fwd2;
        end else begin
            r_valid     <= ValidD;
            r_sh        <= ShD;
            r_shamt_src <= ShamtSrcD;
            r_shamt_imm <= ShamtImmD;
            r_rs1       <= Rs1D;
            r_rs2       <= Rs2D;
            r_rd        <= RdD;
            r_rd1       <= RD1D;
            r_rd2       <= RD2D;
        end
    end

    // Register shift amounts use only the low bits of rs2.
    assign w_shamt = r_shamt_src ? w_fwd2[SHAMT_W-1:0] : r_shamt_imm;

    // Bubbles drive zeros so the shifter produces 0.
    always_comb begin
        ValidE = r_valid;
        ShE    = '0;
        ShamtE = '0;
        ShInE  = '0;
        RdE    = '0;
        if (r_valid) begin
            ShE    = r_sh;
            ShamtE = w_shamt;
            ShInE  = w_fwd1;
            RdE    = r_rd;
        end
    end

    // The decoder never issues the reserved encoding.
    a_no_rsvd_sh: assert property (@(posedge CLK) disable iff (Reset) ShE != SH_RSVD);

endmodule

// File: tb/tb_shift_operand_stage.sv
// Directed bench for shift_operand_stage: vector table plus reset, stall and
// flush sequences.
module tb_shift_operand_stage;

    logic        CLK;
    logic        Reset;
    logic        ValidD;
    logic [1:0]  ShD;
    logic        ShamtSrcD;
    logic [4:0]  ShamtImmD;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  RdD;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic        StallE;
    logic        FlushE;
    logic        RegWriteM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        ValidE;
    logic [1:0]  ShE;
    logic [4:0]  ShamtE;
    logic [31:0] ShInE;
    logic [4:0]  RdE;

    int n_cmp = 0;
    int n_bad = 0;

    shift_operand_stage #(
        .XLEN    (32),
        .SHAMT_W (5)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .ValidD     (ValidD),
        .ShD        (ShD),
        .ShamtSrcD  (ShamtSrcD),
        .ShamtImmD  (ShamtImmD),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdD        (RdD),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .StallE     (StallE),
        .FlushE     (FlushE),
        .RegWriteM  (RegWriteM),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .RegWriteW  (RegWriteW),
        .RdW        (RdW),
        .ResultW    (ResultW),
        .ValidE     (ValidE),
        .ShE        (ShE),
        .ShamtE     (ShamtE),
        .ShInE      (ShInE),
        .RdE        (RdE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        valid;
        logic [1:0]  sh;
        logic        src;
        logic [4:0]  imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        wm;
        logic [4:0]  rdm;
        logic [31:0] alum;
        logic        ww;
        logic [4:0]  rdw;
        logic [31:0] resw;
        logic        ev;
        logic [1:0]  esh;
        logic [4:0]  eshamt;
        logic [31:0] eshin;
        logic [4:0]  erd;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [1:0] esh,
                             input logic [4:0] eshamt, input logic [31:0] eshin,
                             input logic [4:0] erd);
        check({tag, "_valid"}, 32'(ValidE), 32'(ev));
        check({tag, "_sh"},    32'(ShE),    32'(esh));
        check({tag, "_shamt"}, 32'(ShamtE), 32'(eshamt));
        check({tag, "_shin"},  ShInE,       eshin);
        check({tag, "_rd"},    32'(RdE),    32'(erd));
    endtask

    task automatic clear_fwd();
        RegWriteM  = 1'b0;
        RdM        = 5'd0;
        ALUResultM = 32'h0;
        RegWriteW  = 1'b0;
        RdW        = 5'd0;
        ResultW    = 32'h0;
    endtask

    task automatic drive_d(input vec_t v);
        ValidD    = v.valid;
        ShD       = v.sh;
        ShamtSrcD = v.src;
        ShamtImmD = v.imm;
        Rs1D      = v.rs1;
        Rs2D      = v.rs2;
        RdD       = v.rd;
        RD1D      = v.rd1;
        RD2D      = v.rd2;
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'b00, 1'b0, 5'd4, 5'd3, 5'd0, 5'd9, 32'h0000_00F1, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 2'b00, 5'd4, 32'h0000_00F1, 5'd9};
        vecs[1] = '{1'b1, 2'b01, 1'b0, 5'd7, 5'd5, 5'd0, 5'd2, 32'h0000_1234, 32'h0,
                    1'b1, 5'd5, 32'hAAAA_0000, 1'b1, 5'd5, 32'h0000_1111,
                    1'b1, 2'b01, 5'd7, 32'hAAAA_0000, 5'd2};
        vecs[2] = '{1'b1, 2'b10, 1'b0, 5'd1, 5'd0, 5'd0, 5'd3, 32'h0000_0055, 32'h0,
                    1'b1, 5'd0, 32'h0000_DEAD, 1'b1, 5'd0, 32'h0000_BEEF,
                    1'b1, 2'b10, 5'd1, 32'h0000_0055, 5'd3};
        vecs[3] = '{1'b1, 2'b00, 1'b1, 5'd0, 5'd1, 5'd7, 5'd4, 32'h0000_CAFE, 32'h10,
                    1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hFFFF_FF23,
                    1'b1, 2'b00, 5'd3, 32'h0000_CAFE, 5'd4};
        vecs[4] = '{1'b1, 2'b01, 1'b0, 5'd31, 5'd6, 5'd0, 5'd31, 32'h0, 32'h0,
                    1'b1, 5'd8, 32'h1234_5678, 1'b1, 5'd6, 32'h0000_0BAD,
                    1'b1, 2'b01, 5'd31, 32'h0000_0BAD, 5'd31};
        vecs[5] = '{1'b0, 2'b10, 1'b0, 5'd5, 5'd1, 5'd0, 5'd7, 32'h0000_FFFF, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b0, 2'b00, 5'd0, 32'h0, 5'd0};
        vecs[6] = '{1'b1, 2'b00, 1'b1, 5'd9, 5'd2, 5'd2, 5'd10, 32'h3, 32'h4,
                    1'b1, 5'd2, 32'hFFFF_FFFF, 1'b1, 5'd2, 32'h0,
                    1'b1, 2'b00, 5'd31, 32'hFFFF_FFFF, 5'd10};
        vecs[7] = '{1'b1, 2'b01, 1'b1, 5'd9, 5'd0, 5'd0, 5'd11, 32'h77, 32'h25,
                    1'b1, 5'd0, 32'h1F, 1'b1, 5'd0, 32'h0,
                    1'b1, 2'b01, 5'd5, 32'h77, 5'd11};

        Reset  = 1'b1;
        StallE = 1'b0;
        FlushE = 1'b0;
        drive_d(vecs[5]);
        clear_fwd();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0);
        @(negedge CLK);
        Reset = 1'b0;

        // Table: load at one edge, apply forwarding, check before the next edge.
        for (int i = 0; i < 8; i++) begin
            drive_d(vecs[i]);
            clear_fwd();
            @(posedge CLK);
            #1;
            RegWriteM  = vecs[i].wm;
            RdM        = vecs[i].rdm;
            ALUResultM = vecs[i].alum;
            RegWriteW  = vecs[i].ww;
            RdW        = vecs[i].rdw;
            ResultW    = vecs[i].resw;
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].esh, vecs[i].eshamt,
                      vecs[i].eshin, vecs[i].erd);
        end

        // Reset asserted mid-cycle clears outputs without waiting for an edge.
        clear_fwd();
        drive_d(vecs[0]);
        @(posedge CLK);
        #1;
        check_all("pre_rst", 1'b1, 2'b00, 5'd4, 32'h0000_00F1, 5'd9);
        #1;
        Reset = 1'b1;
        #1;
        check_all("mid_rst", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0);
        @(negedge CLK);
        Reset = 1'b0;

        // Stall refresh: WB forwards rs1 only during the first stalled cycle.
        ValidD = 1'b1; ShD = 2'b10; ShamtSrcD = 1'b0; ShamtImmD = 5'd1;
        Rs1D = 5'd4; Rs2D = 5'd0; RdD = 5'd12; RD1D = 32'h1; RD2D = 32'h0;
        @(posedge CLK);
        #1;
        StallE = 1'b1;
        drive_d(vecs[5]);
        RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'h8000_0000;
        #1;
        check_all("stall_c1", 1'b1, 2'b10, 5'd1, 32'h8000_0000, 5'd12);
        @(posedge CLK);
        #1;
        clear_fwd();
        #1;
        check_all("stall_c2", 1'b1, 2'b10, 5'd1, 32'h8000_0000, 5'd12);
        @(posedge CLK);
        #1;
        StallE = 1'b0;
        #1;
        check_all("stall_rel", 1'b1, 2'b10, 5'd1, 32'h8000_0000, 5'd12);
        @(posedge CLK);
        #1;
        check_all("after_rel", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0);

        // Flush and stall on the same edge: flush wins.
        drive_d(vecs[1]);
        @(posedge CLK);
        #1;
        check("pre_flush_valid", 32'(ValidE), 32'h1);
        StallE = 1'b1;
        FlushE = 1'b1;
        @(posedge CLK);
        #1;
        StallE = 1'b0;
        FlushE = 1'b0;
        check_all("flush", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
